// File: rtl/pwm_gen_bank.sv
// pwm_gen_bank: two independent PWM generators (prescaler + 8-bit period
// counter, two compare channels each) routed onto eight registered outputs.
// Duty and divider values are shadowed and only change at a period boundary
// or on restart, so configuration writes never glitch an output mid-period.
module pwm_gen_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_out,
  input  logic [7:0] en_pwm_out,
  input  logic [7:0] out_3_0_sel,
  input  logic [7:0] out_7_4_sel,
  input  logic [7:0] duty_g0c0,
  input  logic [7:0] duty_g0c1,
  input  logic [7:0] duty_g1c0,
  input  logic [7:0] duty_g1c1,
  input  logic [7:0] freq_div,
  input  logic       restart,
  output logic [7:0] out,
  output logic [1:0] period_start
);

  // First cycle out of reset behaves exactly like a restart pulse.
  logic        first_r;
  logic        restart_s;

  // Per-generator state: prescaler, period counter, shadow divider and duties.
  logic [14:0] p_r        [2];
  logic [7:0]  c_r        [2];
  logic [3:0]  div_sh_r   [2];
  logic [7:0]  duty_sh_r  [2][2];

  // Combinational helpers.
  logic [7:0]  duty_live_s [2][2];
  logic [14:0] mask_s      [2];
  logic [1:0]  tick_s;
  logic [1:0]  bnd_s;
  logic [3:0]  ch_s;
  logic [15:0] sel_all_s;
  logic [7:0]  out_nxt_s;

  // Registered outputs.
  logic [7:0]  out_r;
  logic [1:0]  period_start_r;

  // Prescaler wrap, period boundary, channel compares and output mux.
  always_comb begin
    restart_s         = restart | first_r;
    duty_live_s[0][0] = duty_g0c0;
    duty_live_s[0][1] = duty_g0c1;
    duty_live_s[1][0] = duty_g1c0;
    duty_live_s[1][1] = duty_g1c1;
    sel_all_s         = {out_7_4_sel, out_3_0_sel};
    tick_s            = 2'b00;
    bnd_s             = 2'b00;
    ch_s              = 4'b0000;
    out_nxt_s         = 8'h00;
    for (int k = 0; k < 2; k++) begin
      // A prescale exponent D gives a wrap mask of D low ones.
      mask_s[k]       = ~(15'h7fff << div_sh_r[k]);
      tick_s[k]       = (p_r[k] == mask_s[k]);
      bnd_s[k]        = tick_s[k] & (c_r[k] == 8'd254);
      ch_s[2*k]       = (c_r[k] < duty_sh_r[k][0]);
      ch_s[2*k+1]     = (c_r[k] < duty_sh_r[k][1]);
    end
    for (int i = 0; i < 8; i++) begin
      out_nxt_s[i] = en_out[i] & (en_pwm_out[i] ? ch_s[sel_all_s[2*i +: 2]] : 1'b1);
    end
  end

  // Restart-after-reset flag and the registered output pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r <= 1'b1;
      out_r   <= 8'h00;
    end else begin
      first_r <= 1'b0;
      out_r   <= out_nxt_s;
    end
  end

  // Generator counters, shadow loads and period-start pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_start_r <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        p_r[k]          <= 15'd0;
        c_r[k]          <= 8'd0;
        div_sh_r[k]     <= 4'd0;
        duty_sh_r[k][0] <= 8'h00;
        duty_sh_r[k][1] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (restart_s || bnd_s[k]) begin
          // New period: re-phase and capture the live configuration.
          p_r[k]            <= 15'd0;
          c_r[k]            <= 8'd0;
          div_sh_r[k]       <= freq_div[4*k +: 4];
          duty_sh_r[k][0]   <= duty_live_s[k][0];
          duty_sh_r[k][1]   <= duty_live_s[k][1];
          period_start_r[k] <= 1'b1;
        end else begin
          period_start_r[k] <= 1'b0;
          if (tick_s[k]) begin
            p_r[k] <= 15'd0;
            c_r[k] <= c_r[k] + 8'd1;
          end else begin
            p_r[k] <= p_r[k] + 15'd1;
          end
        end
      end
    end
  end

  assign out          = out_r;
  assign period_start = period_start_r;

endmodule
